// File: rtl/hwo_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hwo_seq_ctrl_pkg
// Brief    : Shared constants and state encoding for the obfuscator
//            sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
package hwo_seq_ctrl_pkg;

    // Default widths: ROM address, sequence-length field (length-1), pseudo-PC
    localparam int c_rom_addr_w = 8;
    localparam int c_seq_len_w  = 3;
    localparam int c_ppc_w      = 8;

    // Sequencer state encoding (2 bits)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EMIT = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/hwo_seq_ctrl_ppc.sv
`default_nettype none
// ============================================================================
// Module   : hwo_seq_ctrl_ppc
// Brief    : Enable-driven wrap-around pseudo-PC counter, async active-low
//            reset.
// Revision : 1.0 - initial release
// ============================================================================
module hwo_seq_ctrl_ppc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Count one per enabled cycle; natural wrap at 2^WIDTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hwo_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hwo_seq_ctrl
// Brief    : Fetch-to-decode sequencing controller. Passes instructions
//            through, or stalls fetch and replays a 1..2^LEN_W word
//            substitute sequence read from an external synchronous ROM.
//            Owns the pseudo-PC counting words delivered to decode.
// Revision : 1.0 - initial release
// ============================================================================
module hwo_seq_ctrl
    import hwo_seq_ctrl_pkg::*;
#(
    parameter int ROM_AW = c_rom_addr_w,
    parameter int LEN_W  = c_seq_len_w,
    parameter int PPC_W  = c_ppc_w
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hwo_en,
    input  logic [31:0]       if_insn,
    input  logic              if_valid,
    input  logic              map_hit,
    input  logic [ROM_AW-1:0] map_base,
    input  logic [LEN_W-1:0]  map_len,
    input  logic              id_ready,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [31:0]       io_insn,
    output logic              io_valid,
    output logic              if_stall,
    output logic              busy,
    output logic [PPC_W-1:0]  ppc
);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [ROM_AW-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [31:0]       r_buf;
    logic [ROM_AW-1:0] r_rom_addr;
    logic              w_start;
    logic              w_advance;
    logic              w_ppc_en;

    // Next-state and outputs; everything is forced quiet while reset is low
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_advance   = 1'b0;
        rom_en      = 1'b0;
        rom_addr    = r_rom_addr;
        io_insn     = if_insn;
        io_valid    = 1'b0;
        if_stall    = 1'b0;
        busy        = 1'b0;
        if (rst) begin
            case (r_state)
                ST_IDLE: begin
                    w_start = if_valid & hwo_en & map_hit;
                    if (w_start) begin
                        rom_en      = 1'b1;
                        rom_addr    = map_base;
                        if_stall    = 1'b1;
                        w_state_nxt = ST_READ;
                    end else begin
                        io_valid = if_valid;
                        if_stall = if_valid & ~id_ready;
                    end
                end
                ST_READ: begin
                    busy        = 1'b1;
                    if_stall    = 1'b1;
                    w_state_nxt = ST_EMIT;
                end
                ST_EMIT: begin
                    busy     = 1'b1;
                    io_insn  = r_buf;
                    io_valid = 1'b1;
                    if (!id_ready) begin
                        if_stall = 1'b1;
                    end else if (r_cnt != r_len) begin
                        // Word accepted, more to come: fetch the next one
                        w_advance   = 1'b1;
                        rom_en      = 1'b1;
                        rom_addr    = r_base + ROM_AW'(r_cnt) + ROM_AW'(1);
                        if_stall    = 1'b1;
                        w_state_nxt = ST_READ;
                    end else begin
                        // Last word accepted: release fetch, original is consumed
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequence context, ROM data buffer and last-issued ROM address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_buf      <= '0;
            r_rom_addr <= '0;
        end else begin
            if (w_start) begin
                r_base <= map_base;
                r_len  <= map_len;
                r_cnt  <= '0;
            end
            if (w_advance) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == ST_READ) begin
                r_buf <= rom_data;
            end
            if (rom_en) begin
                r_rom_addr <= rom_addr;
            end
        end
    end

    assign w_ppc_en = io_valid & id_ready;

    hwo_seq_ctrl_ppc #(
        .WIDTH (PPC_W)
    ) u_ppc (
        .clk   (clk),
        .rst   (rst),
        .en    (w_ppc_en),
        .count (ppc)
    );

endmodule
`default_nettype wire

// File: tb/tb_hwo_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hwo_seq_ctrl
// Brief    : Scoreboard testbench for hwo_seq_ctrl with a synchronous ROM
//            model, pseudo-PC reference counter and directed sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hwo_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        hwo_en;
    logic [31:0] if_insn;
    logic        if_valid;
    logic        map_hit;
    logic [7:0]  map_base;
    logic [2:0]  map_len;
    logic        id_ready;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic [31:0] io_insn;
    logic        io_valid;
    logic        if_stall;
    logic        busy;
    logic [7:0]  ppc;

    logic [31:0] rom_mem [256];
    logic [31:0] exp_q [$];
    logic [7:0]  addr_q [$];
    int          m_ppc;
    int          n_checks = 0;
    int          n_fail   = 0;

    hwo_seq_ctrl u_dut (
        .clk      (clk),
        .rst      (rst),
        .hwo_en   (hwo_en),
        .if_insn  (if_insn),
        .if_valid (if_valid),
        .map_hit  (map_hit),
        .map_base (map_base),
        .map_len  (map_len),
        .id_ready (id_ready),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .io_insn  (io_insn),
        .io_valid (io_valid),
        .if_stall (if_stall),
        .busy     (busy),
        .ppc      (ppc)
    );

    always #5 clk = ~clk;

    // Synchronous substitution ROM: data valid the cycle after rom_en
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_mem[rom_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: ROM addresses and delivered words, plus reference pseudo-PC
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("ppc_in_reset", ppc, 32'h0);
            check_eq("io_valid_in_reset", io_valid, 32'h0);
            m_ppc = 0;
            exp_q.delete();
            addr_q.delete();
        end else begin
            check_eq("ppc", ppc, m_ppc);
            if (rom_en) begin
                if (addr_q.size() == 0) check_eq("rom_en_unexpected", rom_en, 32'h0);
                else                    check_eq("rom_addr", rom_addr, addr_q.pop_front());
            end
            if (io_valid && id_ready) begin
                if (exp_q.size() == 0) check_eq("io_valid_unexpected", io_valid, 32'h0);
                else                   check_eq("io_insn", io_insn, exp_q.pop_front());
                m_ppc = (m_ppc + 1) % 256;
            end
        end
    end

    // One passthrough word accepted by decode this cycle
    task automatic pass_word(input logic [31:0] w);
        if_insn  = w;
        if_valid = 1'b1;
        map_hit  = 1'b0;
        id_ready = 1'b1;
        exp_q.push_back(w);
        #1;
        check_eq("pass_io_valid", io_valid, 32'h1);
        check_eq("pass_if_stall", if_stall, 32'h0);
        @(posedge clk); #1;
        if_valid = 1'b0;
    endtask

    // Full substitute sequence; optional backpressure on one word and
    // optional hwo_en drop right after the start cycle
    task automatic run_seq(input logic [7:0] base, input int len, input logic [31:0] orig,
                           input int stall_idx, input int stall_n, input bit drop_en);
        logic [7:0] a;
        if_insn  = orig;
        if_valid = 1'b1;
        hwo_en   = 1'b1;
        map_hit  = 1'b1;
        map_base = base;
        map_len  = 3'(len);
        id_ready = 1'b1;
        for (int i = 0; i <= len; i++) begin
            a = base + 8'(i);
            exp_q.push_back(rom_mem[a]);
            addr_q.push_back(a);
        end
        #1;
        check_eq("start_rom_en", rom_en, 32'h1);
        check_eq("start_rom_addr", rom_addr, base);
        check_eq("start_if_stall", if_stall, 32'h1);
        check_eq("start_io_valid", io_valid, 32'h0);
        for (int i = 0; i <= len; i++) begin
            @(posedge clk); #1;
            map_hit  = 1'b0;
            map_base = ~base;
            if (drop_en) hwo_en = 1'b0;
            #1;
            check_eq("read_io_valid", io_valid, 32'h0);
            check_eq("read_if_stall", if_stall, 32'h1);
            check_eq("read_busy", busy, 32'h1);
            @(posedge clk); #1;
            a = base + 8'(i);
            if (i == stall_idx) begin
                id_ready = 1'b0;
                repeat (stall_n) begin
                    #1;
                    check_eq("stall_io_insn", io_insn, rom_mem[a]);
                    check_eq("stall_if_stall", if_stall, 32'h1);
                    @(posedge clk); #1;
                end
                id_ready = 1'b1;
            end
            #1;
            check_eq("emit_io_valid", io_valid, 32'h1);
            check_eq("emit_if_stall", if_stall, (i == len) ? 32'h0 : 32'h1);
        end
        @(posedge clk); #1;
        if_valid = 1'b0;
        hwo_en   = 1'b1;
        check_eq("seq_done_busy", busy, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p0;
        for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
        rom_mem[8'h10] = 32'hA863_0001;
        rst      = 1'b0;
        hwo_en   = 1'b1;
        if_insn  = 32'h1234_5678;
        if_valid = 1'b1;
        map_hit  = 1'b1;
        map_base = 8'h33;
        map_len  = 3'd1;
        id_ready = 1'b1;
        m_ppc    = 0;

        // Reset values with a would-be start on the inputs
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rom_en", rom_en, 32'h0);
        check_eq("rst_rom_addr", rom_addr, 32'h0);
        check_eq("rst_io_valid", io_valid, 32'h0);
        check_eq("rst_if_stall", if_stall, 32'h0);
        check_eq("rst_busy", busy, 32'h0);
        check_eq("rst_io_insn", io_insn, 32'h1234_5678);
        rst      = 1'b1;
        if_valid = 1'b0;
        map_hit  = 1'b0;
        @(posedge clk); #1;

        // Passthrough, including a backpressured cycle
        if_insn  = 32'h1500_0000;
        if_valid = 1'b1;
        id_ready = 1'b0;
        #1;
        check_eq("pass_bp_if_stall", if_stall, 32'h1);
        @(posedge clk); #1;
        check_eq("pass_bp_ppc", ppc, 32'h0);
        pass_word(32'h1500_0000);
        check_eq("pass_ppc", ppc, 32'h1);

        // Single-word sequence
        p0 = ppc;
        run_seq(8'h10, 0, 32'hDEAD_0001, 99, 0, 1'b0);
        check_eq("single_ppc_delta", 8'(ppc - p0), 32'h1);

        // Three words with ROM address wrap and 3 stall cycles on word 2
        p0 = ppc;
        run_seq(8'hFE, 2, 32'hDEAD_0003, 1, 3, 1'b0);
        check_eq("three_ppc_delta", 8'(ppc - p0), 32'h3);
        check_eq("rom_addr_hold", rom_addr, 32'h00);

        // Enable gating: no sequence with hwo_en low
        hwo_en   = 1'b0;
        if_insn  = 32'h9C21_FFF0;
        if_valid = 1'b1;
        map_hit  = 1'b1;
        id_ready = 1'b1;
        exp_q.push_back(32'h9C21_FFF0);
        #1;
        check_eq("gate_rom_en", rom_en, 32'h0);
        check_eq("gate_io_valid", io_valid, 32'h1);
        @(posedge clk); #1;
        if_valid = 1'b0;
        hwo_en   = 1'b1;

        // hwo_en dropped mid-sequence: both words still emitted
        run_seq(8'h40, 1, 32'hDEAD_0002, 99, 0, 1'b1);

        // Reset asserted during EMIT of a 4-word sequence
        if_insn  = 32'hDEAD_0004;
        if_valid = 1'b1;
        hwo_en   = 1'b1;
        map_hit  = 1'b1;
        map_base = 8'h20;
        map_len  = 3'd3;
        id_ready = 1'b1;
        exp_q.push_back(rom_mem[8'h20]);
        addr_q.push_back(8'h20);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("mid_busy_before", busy, 32'h1);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_io_valid", io_valid, 32'h0);
        check_eq("mid_rst_if_stall", if_stall, 32'h0);
        check_eq("mid_rst_busy", busy, 32'h0);
        check_eq("mid_rst_ppc", ppc, 32'h0);
        @(posedge clk); #1;
        rst     = 1'b1;
        map_hit = 1'b0;
        pass_word(32'h1500_0000);
        check_eq("after_rst_busy", busy, 32'h0);

        // Pseudo-PC wrap
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (255) pass_word($urandom);
        check_eq("ppc_max", ppc, 32'hFF);
        pass_word(32'h1500_0000);
        check_eq("ppc_wrap", ppc, 32'h00);

        repeat (2) @(posedge clk);
        #1;
        check_eq("exp_q_empty", exp_q.size(), 32'h0);
        check_eq("addr_q_empty", addr_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hwo_seq_ctrl.md
Name: hwo_seq_ctrl

Overview:
Sequencing controller for the hardware obfuscator, placed between the OR1200 fetch stage and decode. For each fetched instruction flagged by the index generator / map table, it stalls fetch and replays a substitute sequence of 1..8 words from an external synchronous substitution ROM. All other instructions pass through unchanged. It also owns the pseudo-PC, which counts every instruction word delivered to decode.

Parameters:
ROM_AW, 8, substitution ROM address width
LEN_W, 3, sequence-length field width; map_len encodes (length-1), so lengths are 1..2^LEN_W
PPC_W, 8, pseudo-PC width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low (asserted when 0)
hwo_en  in  1  obfuscation enable; sampled only when a sequence starts
if_insn  in  32  instruction from fetch; held stable by fetch while if_stall=1
if_valid  in  1  if_insn valid
map_hit  in  1  if_insn has a substitution entry (combinational from map table)
map_base  in  ROM_AW  ROM address of the first substitute word
map_len  in  LEN_W  sequence length minus 1
id_ready  in  1  decode accepts io_insn this cycle
rom_en  out  1  ROM read strobe
rom_addr  out  ROM_AW  ROM read address
rom_data  in  32  ROM read data, valid the cycle after rom_en
io_insn  out  32  instruction to decode
io_valid  out  1  io_insn valid
if_stall  out  1  fetch must hold if_insn (instruction not consumed)
busy  out  1  sequence in progress
ppc  out  PPC_W  pseudo-PC

Behaviour:
- Reset: asynchronous, active-low (rst=0). Forces state IDLE and cnt=0. Output values during reset: rom_en=0, rom_addr=0, io_valid=0, if_stall=0, busy=0, ppc=0, io_insn=if_insn (IDLE passthrough). Reset in the middle of a sequence abandons it; no partial words are emitted afterwards.
- States: IDLE, READ, EMIT. busy=1 in READ and EMIT.
- start = if_valid & hwo_en & map_hit & (state==IDLE).
- IDLE, no start: combinational passthrough with zero latency.
  - io_insn=if_insn, io_valid=if_valid, if_stall=if_valid & ~id_ready.
- IDLE, start:
  - io_valid=0, if_stall=1, rom_en=1, rom_addr=map_base.
  - Latch base_q=map_base, len_q=map_len, cnt=0.
  - Next state READ. id_ready is ignored in this cycle.
- READ:
  - rom_en=0, io_valid=0, if_stall=1.
  - Capture rom_data into buf_q. Next state EMIT.
- EMIT:
  - io_insn=buf_q, io_valid=1.
  - id_ready=0: hold all state; if_stall=1; buf_q is stable.
  - id_ready=1 and cnt<len_q: cnt+1; rom_en=1; rom_addr=base_q+cnt+1 (modulo 2^ROM_AW, wrap allowed); if_stall=1; next state READ.
  - id_ready=1 and cnt==len_q: if_stall=0 (fetch advances this edge; the original instruction is consumed); next state IDLE.
- Throughput while sequencing: one word every 2 cycles at best. Sequence latency from start to first io_valid is 2 cycles.
- rom_addr holds its last value when rom_en=0.
- hwo_en, map_hit, map_base and map_len are ignored outside the start cycle. Dropping hwo_en mid-sequence does not abort the sequence.
- if_valid is not re-checked during a sequence; fetch holds if_insn while if_stall=1.
- ppc: increments by 1 on every cycle with io_valid & id_ready, in both passthrough and EMIT. Wraps from 2^PPC_W-1 to 0. No other updates.
- map_len=0 means a single-word sequence: start, READ, EMIT, IDLE.

Decomposition:
- hwo_defines.v:
  - State encodings HWO_SEQ_IDLE/READ/EMIT (2 bits).
  - HWO_PPC_WIDTH, HWO_SEQ_LEN_WIDTH and HWO_ROM_ADDR_WIDTH default constants.
- One natural sub-module: hwo_ppc.
  - Enable-driven PPC_W-bit wrap counter with async active-low reset.
  - Reusable by hwo_top, which currently has an inline PPC.
- Map table and ROM stay external.

Test Plan:
- Passthrough: hwo_en=1, map_hit=0, if_insn=0x15000000, if_valid=1, id_ready=1 -> same cycle io_insn=0x15000000, io_valid=1, if_stall=0; ppc 0->1.
- Single-word sequence: map_hit=1, map_base=0x10, map_len=0, ROM[0x10]=0xA8630001.
  - Cycle0: rom_en=1, rom_addr=0x10, if_stall=1.
  - Cycle2: io_insn=0xA8630001, io_valid=1, if_stall=0.
  - Cycle3: IDLE; ppc+1.
- Three-word sequence with decode backpressure: map_base=0xFE, map_len=2; id_ready=0 for 3 cycles on the second word.
  - rom_addr sequence is 0xFE, 0xFF, 0x00 (wrap).
  - Second word is held stable while id_ready=0.
  - if_stall stays 1 until the third word is accepted.
  - ppc advances by exactly 3.
- Enable gating: hwo_en=0, map_hit=1 -> passthrough, rom_en never asserted. hwo_en dropped in READ of a 2-word sequence -> both words are still emitted.
- Reset mid-sequence: assert rst=0 in EMIT of a 4-word sequence -> immediately io_valid=0, if_stall=0, busy=0, ppc=0. After release with map_hit=0 -> passthrough.
- PPC wrap: preload 255 accepted transfers (PPC_W=8) -> ppc=0xFF. Next accepted transfer -> ppc=0x00.
